// File: rtl/sseg_scan_ctrl_if.sv
// Write/acknowledge channel carrying new display values into sseg_scan_ctrl.
// The master drives the value and strobe; the controller returns the commit pulse.
interface sseg_scan_ctrl_if;
  logic [15:0] data_in;
  logic        data_we;
  logic        data_ack;

  modport master (
    output data_in,
    output data_we,
    input  data_ack
  );

  modport slave (
    input  data_in,
    input  data_we,
    output data_ack
  );
endinterface

// File: rtl/sseg_scan_ctrl.sv
// Four-digit seven-segment scan controller with frame-aligned value updates.
// Optional SSEG_GUARD_EN darkens the anodes for the first two cycles of each slot.
module sseg_scan_ctrl #(
  parameter int DIV = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             lzb,
  sseg_scan_ctrl_if.slave  bus,
  output logic             frame_tick,
  output logic [3:0]       bin_code,
  output logic [3:0]       an
);

  localparam int PW = $clog2(DIV);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t         state;
  logic [PW-1:0]  prescale;
  logic [1:0]     idx;
  logic [15:0]    shown;
  logic [15:0]    pending;
  logic           pend_flag;

  logic [3:0]     nib;
  logic           upper_zero;
  logic [3:0]     disp_code;
  logic [3:0]     disp_an;
  logic           slot_end;
  logic           frame_end;

  assign slot_end  = (prescale == PW'(DIV - 1));
  assign frame_end = slot_end && (idx == 2'd3);

  // Digit k is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    nib        = shown[{idx, 2'b00} +: 4];
    upper_zero = 1'b0;
    case (idx)
      2'd1:    upper_zero = (shown[15:4] == 12'h000);
      2'd2:    upper_zero = (shown[15:8] == 8'h00);
      2'd3:    upper_zero = (shown[15:12] == 4'h0);
      default: upper_zero = 1'b0;
    endcase
    disp_code = (lzb && upper_zero) ? 4'hF : nib;
    disp_an   = ~(4'b0001 << idx);
`ifdef SSEG_GUARD_EN
    if (prescale < PW'(2)) begin
      disp_an = 4'b1111;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      prescale     <= '0;
      idx          <= 2'd0;
      shown        <= 16'h0000;
      pending      <= 16'h0000;
      pend_flag    <= 1'b0;
      an           <= 4'b1111;
      bin_code     <= 4'hF;
      bus.data_ack <= 1'b0;
      frame_tick   <= 1'b0;
    end else begin
      bus.data_ack <= 1'b0;
      frame_tick   <= 1'b0;
      unique case (state)
        IDLE: begin
          an       <= 4'b1111;
          bin_code <= 4'hF;
          prescale <= '0;
          idx      <= 2'd0;
          if (bus.data_we) begin
            shown        <= bus.data_in;
            bus.data_ack <= 1'b1;
          end
          if (en) begin
            state <= SCAN;
          end
        end
        SCAN: begin
          if (!en) begin
            state    <= IDLE;
            an       <= 4'b1111;
            bin_code <= 4'hF;
            prescale <= '0;
            idx      <= 2'd0;
          end else begin
            an       <= disp_an;
            bin_code <= disp_code;
            if (slot_end) begin
              prescale <= '0;
              idx      <= idx + 2'd1;
            end else begin
              prescale <= prescale + PW'(1);
            end
            // Commit only at the frame boundary so a frame never mixes values.
            if (frame_end) begin
              frame_tick <= 1'b1;
              if (pend_flag) begin
                shown        <= pending;
                pend_flag    <= 1'b0;
                bus.data_ack <= 1'b1;
              end
            end
          end
          // A write on the commit cycle lands after the commit and stays pending.
          if (bus.data_we) begin
            pending   <= bus.data_in;
            pend_flag <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with DIV=4 (16-cycle frames).
// Expected anode/code/ack/tick values are hand-derived per cycle.
module tb_sseg_scan_ctrl;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       lzb;
  logic       frame_tick;
  logic [3:0] bin_code;
  logic [3:0] an;
  int         tests  = 0;
  int         failed = 0;
  logic [3:0] anTab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  sseg_scan_ctrl_if bus();

  sseg_scan_ctrl #(.DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .lzb        (lzb),
    .bus        (bus.slave),
    .frame_tick (frame_tick),
    .bin_code   (bin_code),
    .an         (an)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic e, input logic l,
                               input logic w, input logic [15:0] d);
    rst          = r;
    en           = e;
    lzb          = l;
    bus.data_we  = w;
    bus.data_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] ean,
                             input logic [3:0] ecode, input logic eack, input logic eft);
    tests++;
    assert ({an, bin_code, bus.data_ack, frame_tick} === {ean, ecode, eack, eft})
    else begin
      failed++;
      $error("[TB] FAIL %s: an/code/ack/tick observed %b/%h/%b/%b expected %b/%h/%b/%b",
             tag, an, bin_code, bus.data_ack, frame_tick, ean, ecode, eack, eft);
    end
  endtask

  // One 16-cycle frame; codes holds the expected code per digit, stop_at ends it early.
  task automatic runFrame(input string tag, input logic l, input logic [15:0] codes,
                          input logic ack_end, input logic [15:0] we_mask,
                          input logic [15:0] wd, input int stop_at, input logic stop_rst);
    for (int i = 0; i < 16; i++) begin
      int d;
      d = i / 4;
      if (i == stop_at) begin
        applyStimulus(stop_rst, 1'b0, l, we_mask[i], wd);
        checkOutput($sformatf("%s_stop%0d", tag, i), 4'b1111, 4'hF, 1'b0, 1'b0);
        break;
      end
      applyStimulus(1'b0, 1'b1, l, we_mask[i], wd);
      checkOutput($sformatf("%s_c%0d", tag, i), anTab[d], codes[4*d +: 4],
                  ack_end && (i == 15), i == 15);
    end
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("reset", 4'b1111, 4'hF, 1'b0, 1'b0);
    repeat (3) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      checkOutput("idle_hold", 4'b1111, 4'hF, 1'b0, 1'b0);
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h12A4);
    checkOutput("idle_write_ack", 4'b1111, 4'hF, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("scan_entry", 4'b1111, 4'hF, 1'b0, 1'b0);

    runFrame("f_12a4",     1'b0, 16'h12A4, 1'b0, 16'h0000, 16'h0000, -1, 1'b0);
    runFrame("wr_0030",    1'b0, 16'h12A4, 1'b1, 16'h0001, 16'h0030, -1, 1'b0);
    runFrame("lzb_0030",   1'b1, 16'hFF30, 1'b1, 16'h0001, 16'h0000, -1, 1'b0);
    runFrame("lzb_0000",   1'b1, 16'hFFF0, 1'b0, 16'h0000, 16'h0000, -1, 1'b0);
    runFrame("nolzb_0000", 1'b0, 16'h0000, 1'b1, 16'h0001, 16'h1234, -1, 1'b0);
    runFrame("mid_beef",   1'b0, 16'h1234, 1'b1, 16'h0020, 16'hBEEF, -1, 1'b0);
    runFrame("show_beef",  1'b0, 16'hBEEF, 1'b0, 16'h0000, 16'h0000, -1, 1'b0);

    runFrame("wr_2222",    1'b0, 16'hBEEF, 1'b0, 16'h8000, 16'h2222, -1, 1'b0);
    runFrame("coll_1111",  1'b0, 16'hBEEF, 1'b1, 16'h8000, 16'h1111, -1, 1'b0);
    runFrame("show_2222",  1'b0, 16'h2222, 1'b1, 16'h0000, 16'h0000, -1, 1'b0);

    runFrame("en_off",     1'b0, 16'h1111, 1'b0, 16'h0001, 16'h5678, 8, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("off_idle", 4'b1111, 4'hF, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("reenter", 4'b1111, 4'hF, 1'b0, 1'b0);
    runFrame("retained",   1'b0, 16'h1111, 1'b1, 16'h0000, 16'h0000, -1, 1'b0);

    runFrame("rst_mid",    1'b0, 16'h5678, 1'b0, 16'h0001, 16'h9999, 8, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("post_rst", 4'b1111, 4'hF, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("reenter2", 4'b1111, 4'hF, 1'b0, 1'b0);
    runFrame("after_rst",  1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
